// File: rtl/fpu_op_sequencer.sv
// Request-side sequencer in front of the FP multiply/add unit: latches one op,
// strobes the unit, waits for its result (or times out) and hands back a response.
module fpu_op_sequencer #(
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_x_i,
  input  logic [31:0] req_y_i,
  input  logic [6:0]  req_rounding_mode_i,
  output logic [31:0] x_o,
  output logic [31:0] y_o,
  output logic [6:0]  rounding_mode_o,
  output logic        data_ready_o,
  input  logic        data_valid_i,
  input  logic [31:0] z_i,
  input  logic        except_invalid_operation_i,
  input  logic        except_overflow_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_z_o,
  output logic        resp_invalid_o,
  output logic        resp_overflow_o,
  output logic        resp_timeout_o,
  output logic        sticky_invalid_o,
  output logic        sticky_overflow_o,
  input  logic        sticky_clear_i,
  output logic        busy_o
);

  // state | meaning
  // IDLE  | ready for a request, operands hold the last op
  // SETUP | operands settling on x_o/y_o for SETTLE_CYCLES cycles
  // START | one-cycle start strobe to the unit
  // WAIT  | waiting for unit data-valid, bounded by TIMEOUT_CYCLES
  // RESP  | response presented until the consumer accepts it
  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, RESP} state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    SETTLE_MAX  = 4'hf;
  localparam logic [TW-1:0] WAIT_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_MAX    = {TW{1'b1}};
  localparam logic [TW-1:0] WAIT_ZERO   = '0;

  state_t        state, state_next;
  logic          ready_en;
  logic [3:0]    settle_cnt;
  logic [TW-1:0] wait_cnt;
  logic          accept, capture, timeout_hit;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i && ready_en) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: if (settle_cnt == SETTLE_LAST) state_next = START;
      START: state_next = WAIT;
      WAIT: begin
        // the unit may still show the previous op's valid in the first WAIT cycle
        if (data_valid_i && (wait_cnt != WAIT_ZERO)) begin
          capture    = 1'b1;
          state_next = RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = RESP;
        end
      end
      RESP: if (resp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ready_en          <= 1'b0;
      settle_cnt        <= '0;
      wait_cnt          <= '0;
      x_o               <= '0;
      y_o               <= '0;
      rounding_mode_o   <= '0;
      resp_z_o          <= '0;
      resp_invalid_o    <= 1'b0;
      resp_overflow_o   <= 1'b0;
      resp_timeout_o    <= 1'b0;
      sticky_invalid_o  <= 1'b0;
      sticky_overflow_o <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        x_o             <= req_x_i;
        y_o             <= req_y_i;
        rounding_mode_o <= req_rounding_mode_i;
        settle_cnt      <= '0;
      end else if (state == SETUP && settle_cnt != SETTLE_MAX) begin
        settle_cnt <= settle_cnt + 4'd1;
      end
      if (state == START) begin
        wait_cnt <= '0;
      end else if (state == WAIT && wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + TW'(1);
      end
      if (capture) begin
        resp_z_o        <= z_i;
        resp_invalid_o  <= except_invalid_operation_i;
        resp_overflow_o <= except_overflow_i;
        resp_timeout_o  <= 1'b0;
      end else if (timeout_hit) begin
        resp_z_o        <= 32'h7fff_ffff;
        resp_invalid_o  <= 1'b0;
        resp_overflow_o <= 1'b0;
        resp_timeout_o  <= 1'b1;
      end
      // a flag being set wins over a simultaneous clear
      sticky_invalid_o  <= (sticky_invalid_o & ~sticky_clear_i)
                         | (capture & except_invalid_operation_i);
      sticky_overflow_o <= (sticky_overflow_o & ~sticky_clear_i)
                         | (capture & except_overflow_i);
    end
  end

  assign req_ready_o  = ready_en && (state == IDLE);
  assign data_ready_o = (state == START);
  assign resp_valid_o = (state == RESP);
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer: directed vector table, multi-cycle
// corner sequences and randomized ops against a cycle-count reference model.
module tb_fpu_op_sequencer;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 16;
  localparam int LAT_MIN = SETTLE + 3;
  localparam int LAT_TO  = SETTLE + 1 + TIMEOUT;

  logic        clk_i = 0;
  logic        rst_i = 0;
  logic        req_valid_i = 0;
  logic        req_ready_o;
  logic [31:0] req_x_i = 0, req_y_i = 0;
  logic [6:0]  req_rounding_mode_i = 0;
  logic [31:0] x_o, y_o;
  logic [6:0]  rounding_mode_o;
  logic        data_ready_o;
  logic        data_valid_i = 0;
  logic [31:0] z_i = 0;
  logic        except_invalid_operation_i = 0;
  logic        except_overflow_i = 0;
  logic        resp_valid_o;
  logic        resp_ready_i = 0;
  logic [31:0] resp_z_o;
  logic        resp_invalid_o, resp_overflow_o, resp_timeout_o;
  logic        sticky_invalid_o, sticky_overflow_o;
  logic        sticky_clear_i = 0;
  logic        busy_o;

  fpu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_x_i(req_x_i), .req_y_i(req_y_i), .req_rounding_mode_i(req_rounding_mode_i),
    .x_o(x_o), .y_o(y_o), .rounding_mode_o(rounding_mode_o),
    .data_ready_o(data_ready_o), .data_valid_i(data_valid_i), .z_i(z_i),
    .except_invalid_operation_i(except_invalid_operation_i),
    .except_overflow_i(except_overflow_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_z_o(resp_z_o), .resp_invalid_o(resp_invalid_o),
    .resp_overflow_o(resp_overflow_o), .resp_timeout_o(resp_timeout_o),
    .sticky_invalid_o(sticky_invalid_o), .sticky_overflow_o(sticky_overflow_o),
    .sticky_clear_i(sticky_clear_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] x, y;
    logic [6:0]  rm;
    logic [31:0] z;
    logic        inv, ovf;
    int          dly;
    logic        hold;
    int          rwait;
    logic [31:0] ez;
    logic        einv, eovf, eto;
    int          elat;
  } vec_t;

  vec_t vecs[8];
  int   n_checks = 0;
  int   n_pass   = 0;

  // unit model state and bench-side reference state
  int          unit_dly  = 0;
  logic        unit_hold = 0;
  int          pend      = 0;
  logic        m_sinv    = 0;
  logic        m_sovf    = 0;
  logic [31:0] last_x    = 0;
  logic [31:0] last_y    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // one clock, then update the unit model from what the DUT now shows
  task automatic tick();
    @(posedge clk_i); #1;
    if (unit_hold) data_valid_i = 1'b1;
    else if (data_ready_o) begin pend = unit_dly; data_valid_i = 1'b0; end
    else if (pend > 0) begin pend--; data_valid_i = (pend == 0); end
    else data_valid_i = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] x, y, input logic [6:0] rm, input logic [31:0] z,
                       input logic inv, ovf, input int dly, input logic hold, input int rwait,
                       input logic clr_cap, input logic [31:0] ez, input logic einv, eovf, eto,
                       input int elat);
    int lat, pulses;
    check("x_hold", x_o, last_x);
    check("y_hold", y_o, last_y);
    req_x_i = x; req_y_i = y; req_rounding_mode_i = rm;
    z_i = z; except_invalid_operation_i = inv; except_overflow_i = ovf;
    unit_dly = dly; unit_hold = hold;
    check("req_ready_idle", req_ready_o, 1);
    req_valid_i = 1;
    tick();
    req_valid_i = 0;
    lat = 0; pulses = 0;
    while (!resp_valid_o && lat < SETTLE + TIMEOUT + 10) begin
      sticky_clear_i = clr_cap && (lat == elat - 1);
      tick();
      lat++;
      if (data_ready_o) pulses++;
    end
    sticky_clear_i = 0;
    if (!eto) begin
      m_sinv = (clr_cap ? 1'b0 : m_sinv) | einv;
      m_sovf = (clr_cap ? 1'b0 : m_sovf) | eovf;
    end
    check("resp_valid", resp_valid_o, 1);
    check("latency", lat, elat);
    check("start_pulses", pulses, 1);
    check("resp_z", resp_z_o, ez);
    check("resp_invalid", resp_invalid_o, einv);
    check("resp_overflow", resp_overflow_o, eovf);
    check("resp_timeout", resp_timeout_o, eto);
    check("x_out", x_o, x);
    check("y_out", y_o, y);
    check("rm_out", rounding_mode_o, rm);
    check("sticky_invalid", sticky_invalid_o, m_sinv);
    check("sticky_overflow", sticky_overflow_o, m_sovf);
    for (int i = 0; i < rwait; i++) begin
      tick();
      check("resp_hold_valid", resp_valid_o, 1);
      check("resp_hold_z", resp_z_o, ez);
      check("resp_hold_timeout", resp_timeout_o, eto);
      check("resp_hold_req_ready", req_ready_o, 0);
    end
    resp_ready_i = 1;
    tick();
    resp_ready_i = 0;
    check("resp_dropped", resp_valid_o, 0);
    check("idle_busy", busy_o, 0);
    check("idle_req_ready", req_ready_o, 1);
    last_x = x; last_y = y;
  endtask

  // reference: which WAIT cycle (1-based) ends the op, and whether it is a capture
  task automatic predict(input int dly, input logic hold, output logic cap, output int j);
    if (hold) begin cap = 1; j = 2; end
    else if (dly >= 2 && dly <= TIMEOUT) begin cap = 1; j = dly; end
    else begin cap = 0; j = TIMEOUT; end
  endtask

  initial begin
    vecs[0] = '{32'h3fc00000, 32'h4500001a, 7'h00, 32'h45400027, 0, 0, 2, 0, 0,
                32'h45400027, 0, 0, 0, LAT_MIN};
    vecs[1] = '{32'h7f800000, 32'h00000000, 7'h01, 32'h7fffffff, 1, 0, 2, 0, 0,
                32'h7fffffff, 1, 0, 0, LAT_MIN};
    vecs[2] = '{32'h7f000000, 32'hff000000, 7'h02, 32'hff800000, 0, 1, 2, 0, 0,
                32'hff800000, 0, 1, 0, LAT_MIN};
    vecs[3] = '{32'h40000000, 32'h40400000, 7'h03, 32'h12345678, 1, 1, 0, 0, 0,
                32'h7fffffff, 0, 0, 1, LAT_TO};
    vecs[4] = '{32'h3f800000, 32'h3f800000, 7'h04, 32'h3f800000, 0, 0, 3, 0, 10,
                32'h3f800000, 0, 0, 0, SETTLE + 4};
    vecs[5] = '{32'hc0000000, 32'h40000000, 7'h05, 32'hc0800000, 0, 0, 0, 1, 0,
                32'hc0800000, 0, 0, 0, LAT_MIN};
    vecs[6] = '{32'h41200000, 32'h41a00000, 7'h06, 32'h43480000, 0, 0, TIMEOUT, 0, 1,
                32'h43480000, 0, 0, 0, LAT_TO};
    vecs[7] = '{32'h11111111, 32'h22222222, 7'h07, 32'h33333333, 1, 0, 1, 0, 0,
                32'h7fffffff, 0, 0, 1, LAT_TO};

    #1;
    check("rst_x", x_o, 0);
    check("rst_resp_z", resp_z_o, 0);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_req_ready", req_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_data_ready", data_ready_o, 0);
    tick(); tick();
    rst_i = 1;
    #1 check("ready_before_first_edge", req_ready_o, 0);
    tick();
    check("ready_after_release", req_ready_o, 1);

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].x, vecs[i].y, vecs[i].rm, vecs[i].z, vecs[i].inv, vecs[i].ovf,
            vecs[i].dly, vecs[i].hold, vecs[i].rwait, 1'b0, vecs[i].ez, vecs[i].einv,
            vecs[i].eovf, vecs[i].eto, vecs[i].elat);
    unit_hold = 0;
    check("sticky_inv_set", sticky_invalid_o, 1);
    check("sticky_ovf_set", sticky_overflow_o, 1);

    sticky_clear_i = 1;
    tick();
    sticky_clear_i = 0;
    m_sinv = 0; m_sovf = 0;
    check("sticky_inv_clr", sticky_invalid_o, 0);
    check("sticky_ovf_clr", sticky_overflow_o, 0);

    // clear pulsed on the exact capture edge: the captured flag must survive
    do_op(32'h7f800000, 32'h00000000, 7'h00, 32'h7fffffff, 1, 0, 2, 0, 0, 1'b1,
          32'h7fffffff, 1, 0, 0, LAT_MIN);

    // reset while in WAIT abandons the op
    req_x_i = 32'hdeadbeef; req_y_i = 32'hcafef00d; req_rounding_mode_i = 7'h55;
    unit_dly = 0; unit_hold = 0;
    req_valid_i = 1;
    tick();
    req_valid_i = 0;
    for (int i = 0; i < SETTLE + 2; i++) tick();
    check("in_wait_busy", busy_o, 1);
    rst_i = 0;
    #1;
    check("mid_rst_x", x_o, 0);
    check("mid_rst_y", y_o, 0);
    check("mid_rst_rm", rounding_mode_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_resp_valid", resp_valid_o, 0);
    check("mid_rst_req_ready", req_ready_o, 0);
    check("mid_rst_sticky_inv", sticky_invalid_o, 0);
    tick(); tick();
    rst_i = 1;
    pend = 0; m_sinv = 0; m_sovf = 0; last_x = 0; last_y = 0;
    tick();
    check("post_rst_no_resp", resp_valid_o, 0);
    check("post_rst_ready", req_ready_o, 1);
    do_op(32'h42c40666, 32'h41403333, 7'h00, 32'h44932c00, 0, 0, 2, 0, 0, 1'b0,
          32'h44932c00, 0, 0, 0, LAT_MIN);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] rx, ry, rz;
      logic [6:0]  rrm;
      logic        rinv, rovf, rhold, cap;
      int          rdly, j;
      rx = $urandom; ry = $urandom; rz = $urandom;
      rrm = 7'($urandom_range(0, 127));
      rinv = 1'($urandom_range(0, 1));
      rovf = 1'($urandom_range(0, 1));
      rhold = ($urandom_range(0, 7) == 0);
      rdly = $urandom_range(0, TIMEOUT + 3);
      predict(rdly, rhold, cap, j);
      do_op(rx, ry, rrm, rz, rinv, rovf, rdly, rhold, $urandom_range(0, 3), 1'b0,
            cap ? rz : 32'h7fffffff, cap & rinv, cap & rovf, !cap, SETTLE + 1 + j);
      unit_hold = 0;
      if ($urandom_range(0, 3) == 0) begin
        sticky_clear_i = 1;
        tick();
        sticky_clear_i = 0;
        m_sinv = 0; m_sovf = 0;
        check("rand_sticky_clr", {sticky_invalid_o, sticky_overflow_o}, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
- Request-side controller directly upstream of the arithmetic unit (multiplier/adder, fed through the operand decomposition stage).
- Accepts one operation at a time over a valid/ready interface and holds the operands stable on the unit's inputs.
- Pulses the unit's start strobe, waits for the unit's data-valid, then returns result and exception flags over a valid/ready response interface.
- Keeps sticky IEEE exception status and converts a hung unit into a timeout response.

Parameters:
SETTLE_CYCLES, 1, cycles operands are held on x_o/y_o before the start strobe (range 1-15)
TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before a timeout response (range 2-1023)

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_i  input  1  reset, asynchronous, active-low (0 = reset)
req_valid_i  input  1  request present
req_ready_o  output  1  sequencer can accept a request
req_x_i  input  32  operand X (IEEE-754 single)
req_y_i  input  32  operand Y
req_rounding_mode_i  input  7  rounding mode for this op
x_o  output  32  operand X to the unit
y_o  output  32  operand Y to the unit
rounding_mode_o  output  7  rounding mode to the unit
data_ready_o  output  1  one-cycle start strobe to the unit
data_valid_i  input  1  unit result valid
z_i  input  32  unit result
except_invalid_operation_i  input  1  unit invalid-operation flag
except_overflow_i  input  1  unit overflow flag
resp_valid_o  output  1  response present
resp_ready_i  input  1  consumer accepts response
resp_z_o  output  32  captured result
resp_invalid_o  output  1  captured invalid flag
resp_overflow_o  output  1  captured overflow flag
resp_timeout_o  output  1  response produced by timeout
sticky_invalid_o  output  1  accumulated invalid flag
sticky_overflow_o  output  1  accumulated overflow flag
sticky_clear_i  input  1  clear both sticky flags
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - x_o, y_o, rounding_mode_o, and all resp_* outputs clear to 0.
  - data_ready_o, resp_valid_o, sticky_*, busy_o clear to 0.
  - req_ready_o is 0 while reset is asserted; it is 1 from the first edge after release.
  - Reset mid-operation abandons the operation; no response is issued for it.
- States: IDLE, SETUP, START, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i=1, latch req_x_i, req_y_i and req_rounding_mode_i into x_o, y_o and rounding_mode_o, clear the settle counter, and go to SETUP.
- SETUP:
  - Operands held.
  - The settle counter increments each cycle; after SETTLE_CYCLES cycles in SETUP, go to START.
- START:
  - data_ready_o=1 for exactly this one cycle.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - data_ready_o=0; the timeout counter increments each cycle.
  - data_valid_i is ignored in the first WAIT cycle, because the unit may still be showing the previous op's valid. From the second cycle on, data_valid_i=1 captures z_i and both flags into the resp_* registers, sets resp_timeout_o=0, and moves to RESP.
  - If the counter reaches TIMEOUT_CYCLES without capture: resp_z_o=32'h7fffffff, flags 0, resp_timeout_o=1, go to RESP.
  - Capture takes priority when it coincides with the final count.
- RESP:
  - resp_valid_o=1 with stable payload.
  - On resp_ready_i=1: resp_valid_o drops on the next edge and the state returns to IDLE. No back-to-back acceptance in the same cycle.
- Operands x_o/y_o/rounding_mode_o hold their last values after the op completes; they change only on a new request.
- Minimum request-to-response latency is SETTLE_CYCLES+3 cycles from the accept edge to resp_valid_o, for a unit answering on the second WAIT cycle.
- Sticky flags:
  - On a capture from the unit, sticky_x |= captured flag.
  - A timeout does not set the sticky flags.
  - When sticky_clear_i coincides with a set, the set wins.
- Counters: width clog2(TIMEOUT_CYCLES+1) and 4 bits; both saturate and never wrap.
- req_ready_o=0 in all states except IDLE; a req_valid_i held high during busy is not consumed.

Test Plan:
- Unit model answers 2 cycles after data_ready. Request 3fc00000 x 4500001a with model z=45400027 -> exactly one data_ready pulse; resp_z_o=45400027, flags 0, resp_timeout_o=0; latency per formula.
- Model returns 7fffffff with invalid=1 (inf x 0.0), then ff800000 with overflow=1 -> resp flags match; sticky_invalid=1 and sticky_overflow=1 after both ops. Assert sticky_clear_i -> both sticky flags 0.
- Model never asserts data_valid -> resp after TIMEOUT_CYCLES WAIT cycles with resp_z_o=7fffffff and resp_timeout_o=1; sticky flags unchanged.
- Hold resp_ready_i=0 for 10 cycles, then pulse it -> payload stable throughout; req_ready_o=0 throughout; back in IDLE one cycle after the handshake.
- Model holds data_valid_i high continuously from the previous op -> the first WAIT cycle is ignored and capture happens on the second WAIT cycle.
- Drive rst_i low during WAIT -> all outputs immediately 0, no response. A following request 42c40666 x 41403333 (model z=44932c00) completes normally.
